// File: rtl/led_matrix_pkg.sv
// Shared types, defaults and width helper for the row-multiplexed LED matrix driver.
// Imported by the scan timer and the matrix top.
package led_matrix_pkg;

  typedef enum logic {ST_BLANK, ST_SCAN} state_t;

  localparam int DEF_ROWS         = 4;
  localparam int DEF_COLS         = 4;
  localparam int DEF_BRIGHT_W     = 4;
  localparam int DEF_PRESCALE     = 256;
  localparam int DEF_DEAD_CYCLES  = 8;
  localparam int DEF_BLINK_FRAMES = 1464;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cw(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/led_matrix_pwm_scan_timer.sv
// Scan sequencing: dead-time blank, PWM slot scan, row rotation and frame count.
// Boundary is the last SCAN cycle of the last row.
module led_matrix_pwm_scan_timer
  import led_matrix_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int BRIGHT_W     = DEF_BRIGHT_W,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int DEAD_CYCLES  = DEF_DEAD_CYCLES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  localparam int RW = cw(ROWS)
) (
  input  logic                clk,
  input  logic                reset,
  output state_t              o_state,
  output logic [RW-1:0]       o_row,
  output logic [BRIGHT_W-1:0] o_slot,
  output logic                o_boundary,
  output logic                o_blink_wrap
);

  localparam int PW = cw(PRESCALE);
  localparam int DW = cw(DEAD_CYCLES);
  localparam int FW = cw(BLINK_FRAMES);

  state_t              r_state;
  logic [RW-1:0]       r_row;
  logic [BRIGHT_W-1:0] r_slot;
  logic [PW-1:0]       r_pre;
  logic [DW-1:0]       r_dead;
  logic [FW-1:0]       r_frame;

  logic w_pre_last;
  logic w_scan_last;
  logic w_row_last;
  logic w_dead_last;

  assign w_pre_last   = r_pre == PW'(PRESCALE - 1);
  assign w_dead_last  = r_dead == DW'(DEAD_CYCLES - 1);
  assign w_row_last   = r_row == RW'(ROWS - 1);
  assign w_scan_last  = (r_state == ST_SCAN) && w_pre_last
                        && (r_slot == '1);
  assign o_boundary   = w_scan_last && w_row_last;
  assign o_blink_wrap = o_boundary
                        && (r_frame == FW'(BLINK_FRAMES - 1));

  assign o_state = r_state;
  assign o_row   = r_row;
  assign o_slot  = r_slot;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BLANK;
      r_row   <= '0;
      r_slot  <= '0;
      r_pre   <= '0;
      r_dead  <= '0;
      r_frame <= '0;
    end else begin
      unique case (r_state)
        ST_BLANK: begin
          if (w_dead_last) begin
            r_dead  <= '0;
            r_state <= ST_SCAN;
          end else begin
            r_dead <= r_dead + DW'(1);
          end
        end
        ST_SCAN: begin
          if (w_pre_last) begin
            r_pre  <= '0;
            r_slot <= r_slot + BRIGHT_W'(1);
          end else begin
            r_pre <= r_pre + PW'(1);
          end
          if (w_scan_last) begin
            r_state <= ST_BLANK;
            r_row   <= w_row_last ? '0 : r_row + RW'(1);
          end
        end
        default: r_state <= ST_BLANK;
      endcase
      if (o_boundary) begin
        r_frame <= (r_frame == FW'(BLINK_FRAMES - 1))
                   ? '0 : r_frame + FW'(1);
      end
    end
  end

endmodule

// File: rtl/led_matrix_pwm.sv
// Row-multiplexed LED matrix driver with per-LED PWM brightness and blink,
// double-buffered so a whole new image lands on a frame boundary.
module led_matrix_pwm
  import led_matrix_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int BRIGHT_W     = DEF_BRIGHT_W,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int DEAD_CYCLES  = DEF_DEAD_CYCLES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  localparam int N  = ROWS * COLS,
  localparam int AW = cw(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BRIGHT_W:0] wr_data,
  input  logic              commit,
  output logic              commit_pending,
  output logic [ROWS-1:0]   aled,
  output logic [COLS-1:0]   kled_oe,
  output logic              frame_sync,
  output logic              blink_phase
);

  localparam int RW = cw(ROWS);

  state_t              w_state;
  logic [RW-1:0]       w_row;
  logic [BRIGHT_W-1:0] w_slot;
  logic                w_boundary;
  logic                w_blink_wrap;
  logic                w_wr_ok;
  logic [COLS-1:0]     w_kled;
  logic [AW-1:0]       w_idx;
  logic [BRIGHT_W:0]   w_ent;

  logic [BRIGHT_W:0]   r_shadow [N];
  logic [BRIGHT_W:0]   r_active [N];
  logic                r_pending;
  logic                r_phase;
  logic [ROWS-1:0]     r_aled;
  logic [COLS-1:0]     r_kled;
  logic                r_fs;

  led_matrix_pwm_scan_timer #(
    .ROWS        (ROWS),
    .BRIGHT_W    (BRIGHT_W),
    .PRESCALE    (PRESCALE),
    .DEAD_CYCLES (DEAD_CYCLES),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .o_state     (w_state),
    .o_row       (w_row),
    .o_slot      (w_slot),
    .o_boundary  (w_boundary),
    .o_blink_wrap(w_blink_wrap)
  );

  assign w_wr_ok = wr_en && (int'(wr_addr) < N);

  // Blink-flagged LEDs are masked while the blink phase is low.
  always_comb begin
    w_kled = '0;
    w_idx  = '0;
    w_ent  = '0;
    for (int c = 0; c < COLS; c++) begin
      w_idx = AW'(int'(w_row) * COLS + c);
      w_ent = r_active[w_idx];
      w_kled[c] = (w_state == ST_SCAN)
                  && (w_ent[BRIGHT_W-1:0] > w_slot)
                  && !(w_ent[BRIGHT_W] && !r_phase);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aled    <= '0;
      r_kled    <= '0;
      r_fs      <= 1'b0;
      r_pending <= 1'b0;
      r_phase   <= 1'b1;
      for (int i = 0; i < N; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_aled    <= (w_state == ST_SCAN)
                   ? (ROWS'(1) << w_row) : '0;
      r_kled    <= w_kled;
      r_fs      <= w_boundary;
      r_pending <= (r_pending && !w_boundary) || commit;
      if (w_boundary && r_pending) begin
        for (int i = 0; i < N; i++) r_active[i] <= r_shadow[i];
      end
      if (w_wr_ok) r_shadow[wr_addr] <= wr_data;
      if (w_blink_wrap) r_phase <= !r_phase;
    end
  end

  assign aled           = r_aled;
  assign kled_oe        = r_kled;
  assign frame_sync     = r_fs;
  assign commit_pending = r_pending;
  assign blink_phase    = r_phase;

endmodule

// File: tb/tb_led_matrix_pwm.sv
// Randomized bench for led_matrix_pwm against a frame-arithmetic model.
// Expected outputs derive from elapsed cycles, not from the timer registers.
module tb_led_matrix_pwm;

  localparam int ROWS = 3;
  localparam int COLS = 2;
  localparam int BW   = 2;
  localparam int PRE  = 2;
  localparam int DEAD = 2;
  localparam int BF   = 2;
  localparam int N    = ROWS * COLS;
  localparam int AW   = 3;
  localparam int RL   = DEAD + (1 << BW) * PRE;
  localparam int FL   = ROWS * RL;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [BW:0]     wr_data = '0;
  logic            commit = 1'b0;
  logic            commit_pending;
  logic [ROWS-1:0] aled;
  logic [COLS-1:0] kled_oe;
  logic            frame_sync;
  logic            blink_phase;

  led_matrix_pwm #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .BRIGHT_W    (BW),
    .PRESCALE    (PRE),
    .DEAD_CYCLES (DEAD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .commit        (commit),
    .commit_pending(commit_pending),
    .aled          (aled),
    .kled_oe       (kled_oe),
    .frame_sync    (frame_sync),
    .blink_phase   (blink_phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int m;
  int act [N];
  int shd [N];
  bit pend;
  logic [ROWS-1:0] e_aled;
  logic [COLS-1:0] e_kled;
  bit e_fs;
  bit e_bp;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Blink phase is high for BF frames, then low for BF frames.
  function automatic bit phase_at(input int t);
    return ((t / FL) / BF) % 2 == 0;
  endfunction

  task automatic tick();
    int p, row, q, slot, a;
    bit scan, bnd;
    @(posedge clk);
    if (reset) begin
      m = 0;
      pend = 1'b0;
      for (int i = 0; i < N; i++) begin
        act[i] = 0;
        shd[i] = 0;
      end
      e_aled = '0;
      e_kled = '0;
      e_fs = 1'b0;
      e_bp = 1'b1;
    end else begin
      p    = m % FL;
      row  = p / RL;
      q    = p % RL;
      scan = q >= DEAD;
      slot = scan ? (q - DEAD) / PRE : 0;
      bnd  = p == FL - 1;
      e_aled = scan ? ROWS'(1 << row) : '0;
      e_kled = '0;
      for (int c = 0; c < COLS; c++) begin
        a = act[row * COLS + c];
        if (scan && slot < (a % (1 << BW))
            && !(((a >> BW) & 1) == 1 && !phase_at(m)))
          e_kled[c] = 1'b1;
      end
      e_fs = bnd;
      if (bnd && pend)
        for (int i = 0; i < N; i++) act[i] = shd[i];
      pend = (pend && !bnd) || commit;
      if (wr_en && int'(wr_addr) < N) shd[wr_addr] = int'(wr_data);
      m++;
      e_bp = phase_at(m);
    end
    #1;
    chk("out", 32'({aled, kled_oe, frame_sync, commit_pending, blink_phase}),
        32'({e_aled, e_kled, e_fs, pend, e_bp}));
  endtask

  task automatic first_aled_latency();
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (n < 50 && !found) begin
      tick();
      n++;
      if (aled != '0) found = 1'b1;
    end
    chk("first_aled", 32'(n), 32'(DEAD + 1));
  endtask

  task automatic write_led(input int idx, input int val);
    wr_en = 1'b1;
    wr_addr = AW'(idx);
    wr_data = (BW + 1)'(val);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    first_aled_latency();

    write_led(0, 3);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (2 * FL) tick();

    write_led(3, 0);
    write_led(2, 3);
    write_led(1, 7);
    repeat (3 * FL) tick();
    while ((m % FL) != FL - 1) tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (3 * FL) tick();

    write_led(6, 7);
    write_led(7, 7);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (2 * FL) tick();

    for (int i = 0; i < 3000; i++) begin
      wr_en   = $urandom_range(0, 3) == 0;
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = (BW + 1)'($urandom);
      commit  = ($urandom_range(0, 40) == 0)
                || ((m % FL) == FL - 1 && $urandom_range(0, 1) == 1);
      reset   = $urandom_range(0, 1499) == 0;
      tick();
    end
    wr_en = 1'b0;
    commit = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < N; i++) write_led(i, 3);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (2 * FL) tick();
    while ((m % FL) != RL + DEAD + 3) tick();
    chk("row1_lit", 32'(aled), 32'(2));
    reset = 1'b1;
    tick();
    chk("rst_aled", 32'(aled), 32'(0));
    chk("rst_kled", 32'(kled_oe), 32'(0));
    reset = 1'b0;
    first_aled_latency();
    repeat (2 * FL) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
